reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the decode stage of the pipelined core; successor to the single-write/dual-read file.
- Supports N_WR write ports and N_RD read ports with registered reads and optional write-to-read bypass.
- Adds a per-register pending scoreboard (reserve on issue, clear on writeback) so decode can detect RAW hazards.
- Optional hardwired-zero register 0.

---
 rtl/reg_file_mp.sv | 86 ++++++++
 tb/tb_reg_file_mp.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads, optional write-to-read bypass,
// and a per-register pending scoreboard for RAW hazard detection in decode.
module reg_file_mp #(
  parameter int WIDTH     = 16,
  parameter int N_REGS    = 8,
  parameter int N_RD      = 2,
  parameter int N_WR      = 2,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0,
  localparam int AW       = $clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*AW-1:0]     wr_addr,
  input  logic [N_WR*WIDTH-1:0]  wr_data,
  input  logic [N_RD-1:0]        rd_en,
  input  logic [N_RD*AW-1:0]     rd_addr,
  output logic [N_RD*WIDTH-1:0]  rd_data,
  output logic [N_RD-1:0]        rd_pending,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [N_REGS-1:0]      pending_vec
);

  logic [WIDTH-1:0]  regs     [N_REGS];
  logic [WIDTH-1:0]  regs_nxt [N_REGS];
  logic [N_REGS-1:0] wr_hit;
  logic [N_REGS-1:0] pend_nxt;
  logic [WIDTH-1:0]  rd_val   [N_RD];
  logic [N_RD-1:0]   rd_pend_val;

  // Ascending port order lets the highest-index writer to an address win.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_REGS; i++) regs_nxt[i] = regs[i];
    for (int k = 0; k < N_WR; k++) begin
      if (wr_en[k] && !(ZERO_REG0 && wr_addr[k*AW +: AW] == '0)) begin
        wr_hit[wr_addr[k*AW +: AW]]   = 1'b1;
        regs_nxt[wr_addr[k*AW +: AW]] = wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // A reserve outranks a same-cycle writeback: a newer producer is in flight.
  always_comb begin
    pend_nxt = pending_vec & ~wr_hit;
    if (rsv_en) pend_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG0) pend_nxt[0] = 1'b0;
  end

  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      if (BYPASS) begin
        rd_val[j]      = regs_nxt[rd_addr[j*AW +: AW]];
        rd_pend_val[j] = pend_nxt[rd_addr[j*AW +: AW]];
      end else begin
        rd_val[j]      = regs[rd_addr[j*AW +: AW]];
        rd_pend_val[j] = pending_vec[rd_addr[j*AW +: AW]];
      end
      if (ZERO_REG0 && rd_addr[j*AW +: AW] == '0) begin
        rd_val[j]      = '0;
        rd_pend_val[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      pending_vec <= '0;
      rd_data     <= '0;
      rd_pending  <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= regs_nxt[i];
      pending_vec <= pend_nxt;
      for (int j = 0; j < N_RD; j++) begin
        if (rd_en[j]) begin
          rd_data[j*WIDTH +: WIDTH] <= rd_val[j];
          rd_pending[j]             <= rd_pend_val[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three instances (bypass, no-bypass, zero-reg0) share stimulus;
// expected reads are queued with their due cycle and compared against captured outputs.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic        rsv_en;
  logic [2:0]  rsv_addr;

  logic [31:0] rd_data_a, rd_data_b, rd_data_c;
  logic [1:0]  rd_pend_a, rd_pend_b, rd_pend_c;
  logic [7:0]  pv_a, pv_b, pv_c;

  always #5 clk = ~clk;

  reg_file_mp u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pending(rd_pend_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending_vec(pv_a)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pend_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending_vec(pv_b)
  );

  reg_file_mp #(.ZERO_REG0(1'b1)) u_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_pending(rd_pend_c),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending_vec(pv_c)
  );

  typedef struct {
    string       name;
    int          due;
    int          inst;
    int          port;
    logic [15:0] data;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] hd [512][3][2];
  logic        hp [512][3][2];

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_wr(input int k, input logic [2:0] a, input logic [15:0] d);
    wr_en[k] = 1'b1; wr_addr[k*3 +: 3] = a; wr_data[k*16 +: 16] = d;
  endtask

  task automatic set_rd(input int j, input logic [2:0] a);
    rd_en[j] = 1'b1; rd_addr[j*3 +: 3] = a;
  endtask

  task automatic set_rsv(input logic [2:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  // Queue expectations for all three instances, due after the next clock edge.
  task automatic exp3(input string name, input int port,
                      input logic [15:0] da, input logic pa,
                      input logic [15:0] db, input logic pb,
                      input logic [15:0] dc, input logic pc);
    int d;
    d = (cyc + 1) % 512;
    sb.push_back('{name, d, 0, port, da, pa});
    sb.push_back('{name, d, 1, port, db, pb});
    sb.push_back('{name, d, 2, port, dc, pc});
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    #1;
    cyc++;
    c = cyc % 512;
    for (int j = 0; j < 2; j++) begin
      hd[c][0][j] = rd_data_a[j*16 +: 16]; hp[c][0][j] = rd_pend_a[j];
      hd[c][1][j] = rd_data_b[j*16 +: 16]; hp[c][1][j] = rd_pend_b[j];
      hd[c][2][j] = rd_data_c[j*16 +: 16]; hp[c][2][j] = rd_pend_c[j];
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rd_data_a !== '0 || rd_data_b !== '0 || rd_data_c !== '0 ||
        {rd_pend_a, rd_pend_b, rd_pend_c} !== '0 || {pv_a, pv_b, pv_c} !== '0) begin
      errors++;
      $display("FAIL reset_state got rd=%h/%h/%h pv=%h/%h/%h expected all zero",
               rd_data_a, rd_data_b, rd_data_c, pv_a, pv_b, pv_c);
    end
    set_wr(0, 3'd3, 16'h1234); set_rsv(3'd6);
    tick(); idle();
    checks++;
    if (pv_a !== 8'h40 || pv_b !== 8'h40 || pv_c !== 8'h40) begin
      errors++;
      $display("FAIL preload_rsv pv got %h/%h/%h expected 40", pv_a, pv_b, pv_c);
    end
    rst = 1'b1; set_wr(0, 3'd3, 16'h5555); set_rd(0, 3'd3); set_rsv(3'd2);
    tick(); rst = 1'b0; idle();
    checks++;
    if (rd_data_a !== '0 || rd_data_b !== '0 || rd_data_c !== '0 || {pv_a, pv_b, pv_c} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got rd=%h/%h/%h pv=%h/%h/%h expected all zero",
               rd_data_a, rd_data_b, rd_data_c, pv_a, pv_b, pv_c);
    end
    set_rd(0, 3'd3); exp3("reset_rd_r3", 0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  task automatic test_bypass();
    set_wr(0, 3'd5, 16'h0001);
    tick(); idle();
    set_wr(0, 3'd5, 16'hBEEF); set_rd(0, 3'd5); set_rd(1, 3'd5);
    exp3("bypass_p0", 0, 16'hBEEF, 1'b0, 16'h0001, 1'b0, 16'hBEEF, 1'b0);
    exp3("bypass_p1", 1, 16'hBEEF, 1'b0, 16'h0001, 1'b0, 16'hBEEF, 1'b0);
    tick(); idle();
    set_rd(0, 3'd5); exp3("bypass_reread", 0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  task automatic test_collision();
    set_wr(0, 3'd2, 16'h1111); set_wr(1, 3'd2, 16'h2222); set_rd(1, 3'd2);
    exp3("collide_bypass", 1, 16'h2222, 1'b0, 16'h0000, 1'b0, 16'h2222, 1'b0);
    tick(); idle();
    set_rd(0, 3'd2); exp3("collide_stored", 0, 16'h2222, 1'b0, 16'h2222, 1'b0, 16'h2222, 1'b0);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  task automatic test_scoreboard();
    set_rsv(3'd4);
    tick(); idle();
    checks++;
    if (pv_a !== 8'h10 || pv_b !== 8'h10 || pv_c !== 8'h10) begin
      errors++;
      $display("FAIL rsv_r4 pv got %h/%h/%h expected 10", pv_a, pv_b, pv_c);
    end
    set_rd(0, 3'd4); exp3("rd_pending_r4", 0, 16'h0, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1);
    tick(); idle();
    set_wr(1, 3'd4, 16'h00AA); set_rd(0, 3'd4);
    exp3("wb_r4_same", 0, 16'h00AA, 1'b0, 16'h0000, 1'b1, 16'h00AA, 1'b0);
    tick(); idle();
    checks++;
    if (pv_a !== 8'h00 || pv_b !== 8'h00 || pv_c !== 8'h00) begin
      errors++;
      $display("FAIL wb_clear pv got %h/%h/%h expected 00", pv_a, pv_b, pv_c);
    end
    set_rd(0, 3'd4); exp3("wb_r4_after", 0, 16'h00AA, 1'b0, 16'h00AA, 1'b0, 16'h00AA, 1'b0);
    tick(); idle();
    set_rsv(3'd4); set_wr(0, 3'd4, 16'h0BB0); set_rd(1, 3'd4);
    exp3("rsv_wr_same", 1, 16'h0BB0, 1'b1, 16'h00AA, 1'b0, 16'h0BB0, 1'b1);
    tick(); idle();
    checks++;
    if (pv_a !== 8'h10 || pv_b !== 8'h10 || pv_c !== 8'h10) begin
      errors++;
      $display("FAIL rsv_wr_pv got %h/%h/%h expected 10", pv_a, pv_b, pv_c);
    end
    set_rd(1, 3'd4); exp3("rsv_wr_after", 1, 16'h0BB0, 1'b1, 16'h0BB0, 1'b1, 16'h0BB0, 1'b1);
    tick(); idle();
    set_wr(1, 3'd4, 16'h0BB0); set_rsv(3'd7);
    tick(); idle();
    checks++;
    if (pv_a !== 8'h80 || pv_b !== 8'h80 || pv_c !== 8'h80) begin
      errors++;
      $display("FAIL rsv_other_pv got %h/%h/%h expected 80", pv_a, pv_b, pv_c);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  task automatic test_zero_reg();
    set_wr(0, 3'd0, 16'hFFFF); set_rsv(3'd0); set_rd(0, 3'd0);
    exp3("zero_same", 0, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tick(); idle();
    checks++;
    if (pv_a !== 8'h81 || pv_b !== 8'h81 || pv_c !== 8'h80) begin
      errors++;
      $display("FAIL zero_pv got %h/%h/%h expected 81/81/80", pv_a, pv_b, pv_c);
    end
    set_rd(0, 3'd0); exp3("zero_after", 0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    tick(); idle();
    set_wr(1, 3'd0, 16'h0000);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  task automatic test_read_hold();
    set_wr(1, 3'd1, 16'h0042);
    tick(); idle();
    set_rd(0, 3'd1); exp3("hold_first", 0, 16'h0042, 1'b0, 16'h0042, 1'b0, 16'h0042, 1'b0);
    tick(); idle();
    set_wr(0, 3'd1, 16'h0099); set_rsv(3'd1);
    exp3("hold_wr", 0, 16'h0042, 1'b0, 16'h0042, 1'b0, 16'h0042, 1'b0);
    tick(); idle();
    exp3("hold_idle", 0, 16'h0042, 1'b0, 16'h0042, 1'b0, 16'h0042, 1'b0);
    tick(); idle();
    set_rd(0, 3'd1); exp3("hold_release", 0, 16'h0099, 1'b1, 16'h0099, 1'b1, 16'h0099, 1'b1);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v0, v1, z0, z1;
    for (int i = 0; i < 8; i++) begin
      set_wr(i % 2, 3'(i), 16'(16'h1000 + i * 16'h0111));
      tick(); idle();
    end
    checks++;
    if (pv_a !== 8'h00 || pv_b !== 8'h00 || pv_c !== 8'h00) begin
      errors++;
      $display("FAIL b2b_pv got %h/%h/%h expected 00", pv_a, pv_b, pv_c);
    end
    for (int i = 0; i < 8; i++) begin
      v0 = 16'(16'h1000 + i * 16'h0111);
      v1 = 16'(16'h1000 + (7 - i) * 16'h0111);
      z0 = (i == 0) ? 16'h0000 : v0;
      z1 = (i == 7) ? 16'h0000 : v1;
      set_rd(0, 3'(i)); set_rd(1, 3'(7 - i));
      exp3("b2b_p0", 0, v0, 1'b0, v0, 1'b0, z0, 1'b0);
      exp3("b2b_p1", 1, v1, 1'b0, v1, 1'b0, z1, 1'b0);
      tick(); idle();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (hd[e.due][e.inst][e.port] !== e.data || hp[e.due][e.inst][e.port] !== e.pend) begin
        errors++;
        $display("FAIL %s inst=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b", e.name,
                 e.inst, e.port, hd[e.due][e.inst][e.port], hp[e.due][e.inst][e.port], e.data, e.pend);
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_zero_reg();
    test_read_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
